// File: rtl/mult_div_pkg.sv
// Shared constants and encodings for the iterative signed multiply/divide unit.
// Holds the FSM state and op encodings, the iteration count and small two's-complement helpers.
package mult_div_pkg;

    localparam int DATA_W     = 32;
    localparam int ITERATIONS = 32;
    localparam int COUNT_W    = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction

    // Note that 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? neg_val(x) : x;
    endfunction

endpackage

// File: rtl/mult_div_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend bit into the
// remainder, trial-subtract the divisor and shift the resulting quotient bit in.
module div_step
    import mult_div_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quo_out
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // rem_in < divisor, so shifted < 2*divisor and the top bit of diff is a clean borrow flag.
    assign shifted = {rem_in, quo_in[DATA_W-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign rem_out = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_out = {quo_in[DATA_W-2:0], ~diff[DATA_W]};

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit, 32 iterations per op.
// hi/lo hold the last result; done pulses for one cycle at completion.
module mult_div
    import mult_div_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mult_start,
    input  logic              div_start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    state_t               state_reg, state_next;
    op_t                  op_reg;
    logic [COUNT_W-1:0]   count_reg;
    logic [2*DATA_W:0]    booth_reg;
    logic [DATA_W-1:0]    mcand_reg;
    logic [DATA_W-1:0]    rem_reg, quo_reg, divisor_reg;
    logic                 neg_quo_reg, neg_rem_reg, dz_pending_reg;
    logic [DATA_W-1:0]    hi_reg, lo_reg;
    logic                 done_reg, div_zero_reg;

    logic [DATA_W-1:0]    acc;
    logic [DATA_W:0]      acc_sum;
    logic [2*DATA_W:0]    booth_next;
    logic [DATA_W-1:0]    rem_step, quo_step;
    logic [DATA_W-1:0]    quo_signed, rem_signed;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mult_start)
                    state_next = ST_RUN;
                else if (div_start)
                    state_next = (b == '0) ? ST_FINISH : ST_RUN;
            end
            ST_RUN: begin
                if (count_reg == COUNT_W'(ITERATIONS - 1))
                    state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // The add is done one bit wider so that -(-2^31) does not overflow before the shift.
    always_comb begin
        acc = booth_reg[2*DATA_W:DATA_W+1];
        case (booth_reg[1:0])
            2'b01:   acc_sum = {acc[DATA_W-1], acc} + {mcand_reg[DATA_W-1], mcand_reg};
            2'b10:   acc_sum = {acc[DATA_W-1], acc} - {mcand_reg[DATA_W-1], mcand_reg};
            default: acc_sum = {acc[DATA_W-1], acc};
        endcase
        booth_next = {acc_sum, booth_reg[DATA_W:1]};
    end

    div_step u_div_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (divisor_reg),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    assign quo_signed = neg_quo_reg ? neg_val(quo_reg) : quo_reg;
    assign rem_signed = neg_rem_reg ? neg_val(rem_reg) : rem_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            op_reg         <= OP_MULT;
            count_reg      <= '0;
            booth_reg      <= '0;
            mcand_reg      <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            divisor_reg    <= '0;
            neg_quo_reg    <= 1'b0;
            neg_rem_reg    <= 1'b0;
            dz_pending_reg <= 1'b0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            done_reg       <= 1'b0;
            div_zero_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    count_reg <= '0;
                    if (mult_start) begin
                        op_reg         <= OP_MULT;
                        mcand_reg      <= a;
                        booth_reg      <= {{DATA_W{1'b0}}, b, 1'b0};
                        dz_pending_reg <= 1'b0;
                    end else if (div_start) begin
                        op_reg         <= OP_DIV;
                        rem_reg        <= '0;
                        quo_reg        <= abs_val(a);
                        divisor_reg    <= abs_val(b);
                        neg_quo_reg    <= a[DATA_W-1] ^ b[DATA_W-1];
                        neg_rem_reg    <= a[DATA_W-1];
                        dz_pending_reg <= (b == '0);
                    end
                end
                ST_RUN: begin
                    count_reg <= count_reg + COUNT_W'(1);
                    if (op_reg == OP_MULT) begin
                        booth_reg <= booth_next;
                    end else begin
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                    end
                end
                ST_FINISH: begin
                    done_reg <= 1'b1;
                    if (dz_pending_reg) begin
                        div_zero_reg <= 1'b1;
                    end else if (op_reg == OP_MULT) begin
                        hi_reg <= booth_reg[2*DATA_W:DATA_W+1];
                        lo_reg <= booth_reg[DATA_W:1];
                    end else begin
                        hi_reg <= rem_signed;
                        lo_reg <= quo_signed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div.sv
// Directed self-checking bench for mult_div: reset, multiply, divide, divide-by-zero,
// mid-run reset, ignored starts while busy and back-to-back operations.
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start, div_start;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int total = 0;
    int bad   = 0;

    mult_div dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    // Pulse a start for one cycle, then wait (bounded) for done; returns latency and busy cycles.
    task automatic run_op(input logic m, input logic d, input logic [31:0] aa, input logic [31:0] bb,
                          output int lat, output int bcyc);
        @(negedge clk);
        mult_start = m; div_start = d; a = aa; b = bb;
        @(negedge clk);
        mult_start = 1'b0; div_start = 1'b0; a = $urandom; b = $urandom;
        bcyc = busy ? 1 : 0;
        lat  = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bcyc++;
        end
        $display("op %s a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d busy=%0d",
                 m ? "mult" : "div ", aa, bb, hi, lo, div_zero, lat, bcyc);
    endtask

    task automatic test_reset();
        int lat, bcyc;
        reset = 1'b1; mult_start = 1'b1; a = 32'd2; b = 32'd3;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        total++; if ({done, div_zero} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {done, div_zero}); end
        // First edge with reset low accepts the held start.
        reset = 1'b0;
        @(negedge clk);
        mult_start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_first_start: busy got %b want 1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        $display("op mult a=00000002 b=00000003 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        total++; if ({hi, lo} !== 64'd6) begin bad++; $display("FAIL reset_first_result: got %h want 6", {hi, lo}); end
        bcyc = 0;
    endtask

    task automatic test_mult();
        int lat, bcyc;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, lat, bcyc);
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL mult_7xm3: got %h want ffffffffffffffeb", {hi, lo}); end
        total++; if (lat !== 33) begin bad++; $display("FAIL mult_latency: got %0d want 33", lat); end
        total++; if (bcyc !== 33) begin bad++; $display("FAIL mult_busy_cycles: got %0d want 33", bcyc); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL mult_div_zero: got %b want 0", div_zero); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse: got %b want 0", done); end
        run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, lat, bcyc);
        total++; if ({hi, lo} !== 64'h40000000_00000000) begin bad++; $display("FAIL mult_minsq: got %h want 4000000000000000", {hi, lo}); end
        run_op(1'b1, 1'b0, 32'h12345678, 32'h10, lat, bcyc);
        total++; if ({hi, lo} !== 64'h00000001_23456780) begin bad++; $display("FAIL mult_shift: got %h want 0000000123456780", {hi, lo}); end
        run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'h7FFFFFFF, lat, bcyc);
        total++; if ({hi, lo} !== 64'hFFFFFFFF_80000001) begin bad++; $display("FAIL mult_m1xmax: got %h want ffffffff80000001", {hi, lo}); end
        // Both starts together: multiply wins.
        run_op(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcyc);
        total++; if ({hi, lo} !== 64'h00000000_00000001) begin bad++; $display("FAIL mult_both_starts: got %h want 0000000000000001", {hi, lo}); end
    endtask

    task automatic test_div();
        int lat, bcyc;
        run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, lat, bcyc);
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL div_m7_2: got %h want fffffffffffffffd", {hi, lo}); end
        total++; if (lat !== 33) begin bad++; $display("FAIL div_latency: got %0d want 33", lat); end
        run_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, lat, bcyc);
        total++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin bad++; $display("FAIL div_7_m2: got %h want 00000001fffffffd", {hi, lo}); end
        run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bcyc);
        total++; if ({hi, lo} !== 64'h00000000_80000000) begin bad++; $display("FAIL div_min_m1: got %h want 0000000080000000", {hi, lo}); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_min_m1_flag: got %b want 0", div_zero); end
        run_op(1'b0, 1'b1, 32'd100, 32'd7, lat, bcyc);
        total++; if ({hi, lo} !== 64'h00000002_0000000E) begin bad++; $display("FAIL div_100_7: got %h want 000000020000000e", {hi, lo}); end
    endtask

    task automatic test_div_zero();
        int lat, bcyc;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, lat, bcyc);
        run_op(1'b0, 1'b1, 32'd5, 32'd0, lat, bcyc);
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
        total++; if (bcyc !== 1) begin bad++; $display("FAIL dz_busy_cycles: got %0d want 1", bcyc); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", div_zero); end
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL dz_hilo_hold: got %h want ffffffffffffffeb", {hi, lo}); end
        @(negedge clk);
        total++; if ({done, div_zero} !== 2'b00) begin bad++; $display("FAIL dz_flag_clear: got %b want 00", {done, div_zero}); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bcyc, pulses;
        @(negedge clk);
        mult_start = 1'b1; a = 32'h80000000; b = 32'h80000000;
        @(negedge clk);
        mult_start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("op reset at count=10 -> hi=%h lo=%h busy=%b", hi, lo, busy);
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL midreset_hilo: got %h want 0", {hi, lo}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
        pulses = 0;
        repeat (40) begin @(negedge clk); if (done) pulses++; end
        total++; if (pulses !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d pulses want 0", pulses); end
        run_op(1'b1, 1'b0, 32'd3, 32'd4, lat, bcyc);
        total++; if ({hi, lo} !== 64'd12) begin bad++; $display("FAIL midreset_next: got %h want 000000000000000c", {hi, lo}); end
    endtask

    task automatic test_ignore_starts();
        int n, first, pulses;
        @(negedge clk);
        mult_start = 1'b1; a = 32'h0000FFFF; b = 32'h0000FFFF;
        @(negedge clk);
        mult_start = 1'b0; a = 32'd0; b = 32'd0;
        first = -1; pulses = 0;
        for (n = 1; n <= 50; n++) begin
            mult_start = (n == 6); div_start = (n == 21);
            a = (n == 6) ? 32'd1 : 32'd9; b = (n == 6) ? 32'd1 : 32'd3;
            @(negedge clk);
            if (done) begin pulses++; if (first < 0) first = n; end
        end
        mult_start = 1'b0; div_start = 1'b0;
        $display("op mult 0000ffff*0000ffff with restarts -> hi=%h lo=%h first=%0d pulses=%0d", hi, lo, first, pulses);
        total++; if (pulses !== 1) begin bad++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
        total++; if (first !== 33) begin bad++; $display("FAIL ignore_latency: got %0d want 33", first); end
        total++; if ({hi, lo} !== 64'h00000000_FFFE0001) begin bad++; $display("FAIL ignore_result: got %h want 00000000fffe0001", {hi, lo}); end
    endtask

    task automatic test_back_to_back();
        int lat, bcyc;
        run_op(1'b1, 1'b0, 32'd6, 32'd7, lat, bcyc);
        total++; if ({hi, lo} !== 64'd42) begin bad++; $display("FAIL b2b_first: got %h want 000000000000002a", {hi, lo}); end
        // Start the divide in the very cycle done is high.
        div_start = 1'b1; a = 32'hFFFFFF9C; b = 32'd7;
        @(negedge clk);
        div_start = 1'b0;
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_accept: got %b want 10", {busy, done}); end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        $display("op div  a=ffffff9c b=00000007 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        total++; if ({hi, lo} !== 64'hFFFFFFFE_FFFFFFF2) begin bad++; $display("FAIL b2b_div: got %h want fffffffefffffff2", {hi, lo}); end
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    endtask

    initial begin
        reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a = '0; b = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_reset_mid_run();
        test_ignore_starts();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003 mult_start  input  1  one-cycle request: signed multiply a*b.
REQ-004 div_start  input  1  one-cycle request: signed divide a/b.
REQ-005 a  input  32  operand A (multiplicand / dividend), sampled only on the accepting edge.
REQ-006 b  input  32  operand B (multiplier / divisor), sampled only on the accepting edge.
REQ-007 hi  output  32  MULT: upper product word; DIV: remainder.
REQ-008 lo  output  32  MULT: lower product word; DIV: quotient.
REQ-009 busy  output  1  high whenever FSM is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse; drives the control unit's mult-end input.
REQ-011 div_zero  output  1  high together with done when a divide had b==0; low otherwise.

Function
REQ-012 FSM states IDLE, RUN, FINISH; state encoding and op flag (MULT/DIV) held in registers.
REQ-013 IDLE, edge E0 with mult_start=1: latch a, b, op=MULT, count=0, go RUN.
REQ-014 IDLE, edge E0 with div_start=1 and b!=0: latch |a|, |b|, sign bits, op=DIV, count=0, go RUN.
REQ-015 IDLE, edge E0 with div_start=1 and b==0: go FINISH directly with div_zero pending; no iterations.
REQ-016 mult_start and div_start both high in IDLE: MULT accepted, div_start ignored.
REQ-017 Any start asserted while busy=1: ignored; running operation undisturbed.
REQ-018 RUN: one iteration per edge E1..E32; count increments 0..31; on the edge where count==31, go FINISH.
REQ-019 MULT iteration: radix-2 Booth step on a 65-bit {acc, multiplier, q-1} register, arithmetic right shift; full 64-bit two's-complement product.
REQ-020 DIV iteration: restoring step on unsigned magnitudes (shift remainder left, trial subtract, set quotient bit).
REQ-021 FINISH, edge E33 (E1 for divide-by-zero): update hi/lo, register done=1 for exactly one cycle, go IDLE.
REQ-022 MULT result: hi = product[63:32], lo = product[31:0].
REQ-023 DIV result: quotient truncates toward zero; negated if sign(a) xor sign(b); remainder takes sign of a.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0; no flag.
REQ-025 Divide-by-zero: hi and lo hold previous values; done=1 and div_zero=1 in the same cycle.
REQ-026 Latency: done high in the cycle after E33 (nonzero ops), after E1 (b==0); busy high from after E0 until after that edge.
REQ-027 hi/lo change only on completion edges and reset; stable otherwise, readable at any time.
REQ-028 done and div_zero low in every cycle except the completion cycle.

Reset
REQ-029 reset=1 on any edge, including mid-RUN: state=IDLE, count=0, hi=0, lo=0, done=0, div_zero=0, busy=0; the operation in progress is discarded.
REQ-030 reset has priority over mult_start/div_start on the same edge; the first start is accepted on the first edge with reset=0.

Structure
REQ-031 Shared package mult_div_pkg holds the FSM state encoding, op encoding and ITERATIONS=32 constant.
REQ-032 One combinational sub-module div_step (remainder/quotient shift-subtract step) is natural; the Booth step stays inline.

Verification
REQ-033 mult a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done at the cycle after E33, busy for 33 cycles.
REQ-034 mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-035 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
REQ-036 div a=5, b=0 with hi/lo preloaded by a prior mult -> done and div_zero after E1, hi/lo unchanged.
REQ-037 reset pulsed at count=10 of a mult -> hi=lo=0, busy=0, no done; a new mult 3*4 then yields lo=12, hi=0.
REQ-038 mult_start re-pulsed at count=5 and div_start at count=20 of a running mult -> ignored; single done with the original product.
